// File: rtl/scv_pkg.sv
// Shared video types and default counter widths for the scv video path.
package scv_pkg;

    // Pixel counter width (up to 2047 pixels per line).
    localparam int unsigned PIX_W  = 11;
    // Line counter width (up to 1023 lines per frame).
    localparam int unsigned LINE_W = 10;

    // Active-picture geometry measured over one frame.
    typedef struct packed {
        logic [LINE_W-1:0] first;
        logic [LINE_W-1:0] last;
        logic [PIX_W-1:0]  width;
    } vid_geom_t;

endpackage

// File: rtl/scv_vid_geom.sv
// Sync edge detection, pixel/line counters and the per-frame geometry latch.
// The *_d outputs expose the post-update view of this pixel so the output
// stage can blank the sample that moves the line counter or latches a frame.
module scv_vid_geom
    import scv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pce_i,
    input  logic              de_i,
    input  logic              hs_i,
    input  logic              vs_i,
    output logic [LINE_W-1:0] line_d_o,
    output vid_geom_t         geom_d_o,
    output logic              valid_d_o,
    output vid_geom_t         geom_o,
    output logic [LINE_W-1:0] act_h_o,
    output logic              valid_o,
    output logic              frame_tog_o
);

    logic              hs_q, hs_d, vs_q, vs_d;
    logic              hs_rise, vs_rise;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              had_de_q, had_de_d;
    logic              first_seen_q, first_seen_d;
    logic [LINE_W-1:0] first_q, first_d, last_q, last_d;
    logic [PIX_W-1:0]  maxw_q, maxw_d;
    vid_geom_t         geom_q, geom_d;
    logic [LINE_W-1:0] act_h_q, act_h_d;
    logic              valid_q, valid_d;
    logic              tog_q, tog_d;

    // Next state: closing-line bookkeeping first, then frame latch, then line reset.
    always_comb begin
        hs_d         = hs_q;
        vs_d         = vs_q;
        pix_d        = pix_q;
        line_d       = line_q;
        had_de_d     = had_de_q;
        first_seen_d = first_seen_q;
        first_d      = first_q;
        last_d       = last_q;
        maxw_d       = maxw_q;
        geom_d       = geom_q;
        act_h_d      = act_h_q;
        valid_d      = valid_q;
        tog_d        = tog_q;
        hs_rise      = hs_i & ~hs_q;
        vs_rise      = vs_i & ~vs_q;
        if (pce_i) begin
            hs_d = hs_i;
            vs_d = vs_i;
            if (de_i) begin
                had_de_d = 1'b1;
                if (pix_q != '1) pix_d = pix_q + 1'b1;
            end
            if (hs_rise) begin
                if (had_de_q) begin
                    if (!first_seen_q) begin
                        first_d      = line_q;
                        first_seen_d = 1'b1;
                    end
                    last_d = line_q;
                    if (pix_q > maxw_q) maxw_d = pix_q;
                end
                pix_d    = '0;
                had_de_d = 1'b0;
                if (line_q != '1) line_d = line_q + 1'b1;
            end
            if (vs_rise) begin
                if (first_seen_d) begin
                    geom_d.first = first_d;
                    geom_d.last  = last_d;
                    geom_d.width = maxw_d;
                    act_h_d      = last_d - first_d + 1'b1;
                    valid_d      = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
                first_seen_d = 1'b0;
                maxw_d       = '0;
                line_d       = '0;
                tog_d        = ~tog_q;
            end
        end
    end

    // Stream state register; everything holds while pce_i is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            pix_q        <= '0;
            line_q       <= '0;
            had_de_q     <= 1'b0;
            first_seen_q <= 1'b0;
            first_q      <= '0;
            last_q       <= '0;
            maxw_q       <= '0;
            geom_q       <= '0;
            act_h_q      <= '0;
            valid_q      <= 1'b0;
            tog_q        <= 1'b0;
        end else begin
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            pix_q        <= pix_d;
            line_q       <= line_d;
            had_de_q     <= had_de_d;
            first_seen_q <= first_seen_d;
            first_q      <= first_d;
            last_q       <= last_d;
            maxw_q       <= maxw_d;
            geom_q       <= geom_d;
            act_h_q      <= act_h_d;
            valid_q      <= valid_d;
            tog_q        <= tog_d;
        end
    end

    assign line_d_o    = line_d;
    assign geom_d_o    = geom_d;
    assign valid_d_o   = valid_d;
    assign geom_o      = geom_q;
    assign act_h_o     = act_h_q;
    assign valid_o     = valid_q;
    assign frame_tog_o = tog_q;

endmodule

// File: rtl/scv_vid_blank.sv
// Video output conditioner after scv: registered sync/RGB, separate H/V blank
// derived from the previous frame's measured active window, and geometry outputs.
module scv_vid_blank
    import scv_pkg::*;
(
    input  logic              CLK,
    input  logic              RESB,
    input  logic              IN_PCE,
    input  logic              IN_DE,
    input  logic              IN_HS,
    input  logic              IN_VS,
    input  logic [23:0]       IN_RGB,
    output logic              OUT_PCE,
    output logic              OUT_HBLANK,
    output logic              OUT_VBLANK,
    output logic              OUT_DE,
    output logic              OUT_HS,
    output logic              OUT_VS,
    output logic [23:0]       OUT_RGB,
    output logic [PIX_W-1:0]  ACT_W,
    output logic [LINE_W-1:0] ACT_H,
    output logic              GEOM_VALID,
    output logic              FRAME_TOG
);

    logic [LINE_W-1:0] line_d;
    vid_geom_t         geom_d, geom_q;
    logic              valid_d;
    logic              vblank_d;
    logic [23:0]       rgb_d;

    logic              pce_q, hblank_q, vblank_q, hs_q, vs_q;
    logic [23:0]       rgb_q;

    scv_vid_geom u_geom (
        .clk         (CLK),
        .rst_n       (RESB),
        .pce_i       (IN_PCE),
        .de_i        (IN_DE),
        .hs_i        (IN_HS),
        .vs_i        (IN_VS),
        .line_d_o    (line_d),
        .geom_d_o    (geom_d),
        .valid_d_o   (valid_d),
        .geom_o      (geom_q),
        .act_h_o     (ACT_H),
        .valid_o     (GEOM_VALID),
        .frame_tog_o (FRAME_TOG)
    );

    // Vertical blank outside the measured window; a saturated line counter stays blanked.
    always_comb begin
        vblank_d = ~valid_d | (line_d < geom_d.first) | (line_d > geom_d.last) | (line_d == '1);
        rgb_d    = (IN_DE & ~vblank_d) ? IN_RGB : '0;
    end

    // Output register stage: PCE every clock, the rest on pixel-enable cycles.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            pce_q    <= 1'b0;
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            rgb_q    <= '0;
        end else begin
            pce_q <= IN_PCE;
            if (IN_PCE) begin
                hblank_q <= ~IN_DE;
                vblank_q <= vblank_d;
                hs_q     <= IN_HS;
                vs_q     <= IN_VS;
                rgb_q    <= rgb_d;
            end
        end
    end

    assign OUT_PCE    = pce_q;
    assign OUT_HBLANK = hblank_q;
    assign OUT_VBLANK = vblank_q;
    assign OUT_DE     = ~(hblank_q | vblank_q);
    assign OUT_HS     = hs_q;
    assign OUT_VS     = vs_q;
    assign OUT_RGB    = rgb_q;
    assign ACT_W      = geom_q.width;

endmodule

// File: tb/tb_scv_vid_blank.sv
// Bench for scv_vid_blank: frames are described as a per-line DE-width table;
// expected geometry comes from scanning that table, expected outputs from the
// frame line number and the geometry of the previous complete frame.
module tb_scv_vid_blank;

    logic        CLK = 1'b0;
    logic        RESB;
    logic        IN_PCE, IN_DE, IN_HS, IN_VS;
    logic [23:0] IN_RGB;
    logic        OUT_PCE, OUT_HBLANK, OUT_VBLANK, OUT_DE, OUT_HS, OUT_VS;
    logic [23:0] OUT_RGB;
    logic [10:0] ACT_W;
    logic [9:0]  ACT_H;
    logic        GEOM_VALID, FRAME_TOG;

    always #5 CLK = ~CLK;

    scv_vid_blank dut (
        .CLK        (CLK),
        .RESB       (RESB),
        .IN_PCE     (IN_PCE),
        .IN_DE      (IN_DE),
        .IN_HS      (IN_HS),
        .IN_VS      (IN_VS),
        .IN_RGB     (IN_RGB),
        .OUT_PCE    (OUT_PCE),
        .OUT_HBLANK (OUT_HBLANK),
        .OUT_VBLANK (OUT_VBLANK),
        .OUT_DE     (OUT_DE),
        .OUT_HS     (OUT_HS),
        .OUT_VS     (OUT_VS),
        .OUT_RGB    (OUT_RGB),
        .ACT_W      (ACT_W),
        .ACT_H      (ACT_H),
        .GEOM_VALID (GEOM_VALID),
        .FRAME_TOG  (FRAME_TOG)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: geometry of the last complete frame and the frame in flight.
    int m_valid, m_first, m_last, m_w, m_h, m_tog;
    int pend_seen, pend_first, pend_last, pend_w;
    int e_pce, e_hb, e_vb, e_hs, e_vs;
    logic [23:0] e_rgb;
    bit gap_mode;
    int wid[64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_first = 0; m_last = 0; m_w = 0; m_h = 0; m_tog = 0;
        pend_seen = 0; pend_first = 0; pend_last = 0; pend_w = 0;
        e_pce = 0; e_hb = 1; e_vb = 1; e_hs = 0; e_vs = 0; e_rgb = '0;
    endtask

    task automatic check_outputs();
        chk("pce",    32'(OUT_PCE),    32'(e_pce));
        chk("hblank", 32'(OUT_HBLANK), 32'(e_hb));
        chk("vblank", 32'(OUT_VBLANK), 32'(e_vb));
        chk("de",     32'(OUT_DE),     32'(!(e_hb || e_vb)));
        chk("hs",     32'(OUT_HS),     32'(e_hs));
        chk("vs",     32'(OUT_VS),     32'(e_vs));
        chk("rgb",    32'(OUT_RGB),    32'(e_rgb));
        chk("act_w",  32'(ACT_W),      32'(m_w));
        chk("act_h",  32'(ACT_H),      32'(m_h));
        chk("valid",  32'(GEOM_VALID), 32'(m_valid));
        chk("tog",    32'(FRAME_TOG),  32'(m_tog));
    endtask

    // One CLK: drive, advance past the edge, update the model, compare.
    task automatic step(input bit pce, input bit de, input bit hs, input bit vs,
                        input logic [23:0] rgb, input int ln, input bit vs_start);
        IN_PCE = pce; IN_DE = de; IN_HS = hs; IN_VS = vs; IN_RGB = rgb;
        @(posedge CLK);
        #1;
        e_pce = pce;
        if (pce) begin
            if (vs_start) begin
                if (pend_seen != 0) begin
                    m_valid = 1; m_first = pend_first; m_last = pend_last;
                    m_w = pend_w; m_h = pend_last - pend_first + 1;
                end else begin
                    m_valid = 0;
                end
                m_tog = m_tog ^ 1;
                pend_seen = 0;
            end
            e_vb  = (m_valid == 0 || ln < m_first || ln > m_last) ? 1 : 0;
            e_hb  = de ? 0 : 1;
            e_hs  = hs;
            e_vs  = vs;
            e_rgb = (de && e_vb == 0) ? rgb : '0;
        end
        check_outputs();
    endtask

    task automatic pix(input bit de, input bit hs, input bit vs, input int ln, input bit vs_start);
        if (gap_mode)
            repeat (3) step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom), ln, 1'b0);
        step(1'b1, de, hs, vs, 24'($urandom), ln, vs_start);
    endtask

    // Line = 2 HS + 3 back porch + wid[ln] DE pixels + 3 front porch; VS on lines 0..2.
    task automatic send_frame(input int nlines, input int abort_ln);
        for (int ln = 0; ln < nlines; ln++) begin
            int w;
            w = wid[ln];
            for (int s = 0; s < 8 + w; s++) begin
                if (ln == abort_ln && s == 5 + w / 2) return;
                pix(s >= 5 && s < 5 + w, s < 2, ln < 3, ln, ln == 0 && s == 0);
            end
        end
        pend_seen = 0; pend_w = 0;
        for (int i = 0; i < nlines; i++) begin
            if (wid[i] > 0) begin
                if (pend_seen == 0) begin
                    pend_first = i;
                    pend_seen  = 1;
                end
                pend_last = i;
                if (wid[i] > pend_w) pend_w = wid[i];
            end
        end
    endtask

    task automatic fill(input int a, input int b, input int w);
        for (int i = 0; i < 64; i++) wid[i] = (i >= a && i <= b) ? w : 0;
    endtask

    task automatic fill_rand();
        int a, b;
        a = int'($urandom_range(0, 15));
        b = int'($urandom_range(a, 29));
        fill(0, -1, 0);
        for (int i = a; i <= b; i++)
            wid[i] = ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, 40));
        wid[a] = int'($urandom_range(1, 40));
    endtask

    task automatic do_reset();
        #2;
        RESB = 1'b0;
        IN_PCE = 1'b0; IN_DE = 1'b0; IN_HS = 1'b0; IN_VS = 1'b0; IN_RGB = '0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge CLK);
        #2;
        RESB = 1'b1;
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    initial begin
        RESB = 1'b0;
        IN_PCE = 1'b0; IN_DE = 1'b0; IN_HS = 1'b0; IN_VS = 1'b0; IN_RGB = '0;
        gap_mode = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_outputs();
        @(negedge CLK);
        RESB = 1'b1;
        @(posedge CLK);
        #1;

        // Two identical frames: the first is blanked, the second shows the window.
        fill(4, 25, 20);
        send_frame(30, -1);
        send_frame(30, -1);

        // Mixed widths within a frame; widest must win.
        fill(0, -1, 0);
        for (int i = 4; i <= 25; i++) wid[i] = (i % 3 == 0) ? 15 : ((i % 3 == 1) ? 17 : 16);
        send_frame(30, -1);
        chk("actw_frame2", 32'(ACT_W), 32'd20);
        chk("acth_frame2", 32'(ACT_H), 32'd22);
        chk("valid_frame2", 32'(GEOM_VALID), 32'd1);

        // DE on the closing line, so HS and VS rise together after a DE line.
        fill(10, 29, 12);
        send_frame(30, -1);
        chk("actw_mixed", 32'(ACT_W), 32'd17);

        // Frame without DE drops GEOM_VALID but keeps the old geometry.
        fill(0, -1, 0);
        send_frame(30, -1);
        chk("acth_closing_line", 32'(ACT_H), 32'd20);
        chk("actw_closing", 32'(ACT_W), 32'd12);

        fill_rand();
        send_frame(30, -1);
        chk("valid_after_empty", 32'(GEOM_VALID), 32'd0);
        chk("actw_kept", 32'(ACT_W), 32'd12);

        repeat (3) begin
            fill_rand();
            send_frame(30, -1);
        end

        // Pixel enable gapped 1-in-4 with garbage on the idle cycles.
        gap_mode = 1'b1;
        repeat (2) begin
            fill_rand();
            send_frame(30, -1);
        end
        gap_mode = 1'b0;

        // Reset in the middle of a DE line, then recover.
        fill_rand();
        wid[12] = 30;
        send_frame(30, 12);
        do_reset();
        fill_rand();
        send_frame(30, -1);
        fill_rand();
        send_frame(30, -1);
        chk("valid_recover", 32'(GEOM_VALID), 32'd1);
        fill_rand();
        send_frame(30, -1);
        fill(0, -1, 0);
        send_frame(4, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
